// File: rtl/mem_bus_arbiter.sv
// Avalon-MM master front-end: arbitrates NUM_PORTS requesters onto one bus,
// one transaction in flight, with optional waitrequest timeout.
module mem_bus_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ARB_MODE   = 0,
  parameter int WAIT_LIMIT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   req_valid,
  input  logic [NUM_PORTS-1:0]   req_write,
  input  logic [32*NUM_PORTS-1:0] req_addr,
  input  logic [32*NUM_PORTS-1:0] req_wdata,
  input  logic [4*NUM_PORTS-1:0] req_byteenable,
  output logic [NUM_PORTS-1:0]   req_ready,
  output logic [NUM_PORTS-1:0]   resp_valid,
  output logic                   resp_err,
  output logic [31:0]            resp_rdata,
  output logic [31:0]            address,
  output logic [31:0]            writedata,
  output logic [3:0]             byteenable,
  output logic                   read,
  output logic                   write,
  input  logic                   waitrequest,
  input  logic [31:0]            readdata,
  output logic                   busy
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT     = CW'(WAIT_LIMIT);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr, grant_idx, grant_reg;
  logic            grant_found;
  logic [CW-1:0]   wait_cnt, wait_inc;
  logic            lat_write;
  logic [31:0]     lat_addr, lat_wdata;
  logic [3:0]      lat_be;
  logic            accept, complete, abort;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign wait_inc = wait_cnt + CW'(1);

  // Round-robin searches upward from ptr with wrap; fixed priority searches from 0.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 1) sum = (PW+1)'(i);
      else               sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_PORTS)) sum = sum - (PW+1)'(NUM_PORTS);
      idx = sum[PW-1:0];
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (grant_found && reset) begin
          accept     = 1'b1;
          req_ready  = onehot(grant_idx);
          state_next = BUS;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (WAIT_LIMIT > 0 && wait_inc == LIMIT) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Request latch, arbitration pointer, wait counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      grant_reg  <= '0;
      wait_cnt   <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      if (accept) begin
        lat_write <= req_write[grant_idx];
        lat_addr  <= req_addr[{grant_idx, 5'd0} +: 32];
        lat_wdata <= req_wdata[{grant_idx, 5'd0} +: 32];
        lat_be    <= req_byteenable[{grant_idx, 2'd0} +: 4];
        grant_reg <= grant_idx;
        wait_cnt  <= '0;
        if (ARB_MODE == 0)
          ptr <= (grant_idx == LAST_PORT) ? '0 : grant_idx + PW'(1);
      end
      if (state == BUS && waitrequest) wait_cnt <= wait_inc;
      if (complete) begin
        resp_valid <= onehot(grant_reg);
        resp_err   <= 1'b0;
        if (!lat_write) resp_rdata <= readdata;
      end
      if (abort) begin
        resp_valid <= onehot(grant_reg);
        resp_err   <= 1'b1;
      end
    end
  end

  assign address    = lat_addr;
  assign writedata  = lat_wdata;
  assign byteenable = lat_be;
  assign read       = (state == BUS) && !lat_write;
  assign write      = (state == BUS) && lat_write;
  assign busy       = (state == BUS);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level arbitration model
// predicts grants, bus beats and responses; independent monitors check them.
module tb_mem_bus_arbiter;

  localparam int NP = 4;
  localparam int WL = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic [NP-1:0]    req_valid      = '0;
  logic [NP-1:0]    req_write      = '0;
  logic [32*NP-1:0] req_addr       = '0;
  logic [32*NP-1:0] req_wdata      = '0;
  logic [4*NP-1:0]  req_byteenable = '0;
  logic [NP-1:0]    req_ready, resp_valid;
  logic             resp_err, read, write, busy;
  logic [31:0]      resp_rdata, address, writedata;
  logic [3:0]       byteenable;
  logic             waitrequest = 1'b1;
  logic [31:0]      readdata    = '0;

  logic [NP-1:0]    fp_req_valid = '0;
  logic [NP-1:0]    fp_req_ready, fp_resp_valid;
  logic             fp_resp_err, fp_read, fp_write, fp_busy;
  logic [31:0]      fp_resp_rdata, fp_address, fp_writedata;
  logic [3:0]       fp_byteenable;

  mem_bus_arbiter #(.NUM_PORTS(NP), .ARB_MODE(0), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byteenable(req_byteenable),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .address(address), .writedata(writedata),
    .byteenable(byteenable), .read(read), .write(write),
    .waitrequest(waitrequest), .readdata(readdata), .busy(busy)
  );

  mem_bus_arbiter #(.NUM_PORTS(NP), .ARB_MODE(1), .WAIT_LIMIT(0)) dut_fp (
    .clk(clk), .reset(reset),
    .req_valid(fp_req_valid), .req_write('0), .req_addr({NP{32'h0000_0100}}),
    .req_wdata('0), .req_byteenable('1),
    .req_ready(fp_req_ready), .resp_valid(fp_resp_valid), .resp_err(fp_resp_err),
    .resp_rdata(fp_resp_rdata), .address(fp_address), .writedata(fp_writedata),
    .byteenable(fp_byteenable), .read(fp_read), .write(fp_write),
    .waitrequest(1'b0), .readdata(32'h0), .busy(fp_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    int          waits;
  } txn_t;

  typedef struct {
    int          port;
    logic        err;
    logic        wr;
    logic [31:0] rdata;
    int          len;
  } resp_t;

  txn_t  pend [NP][64];
  int    pend_n [NP];
  int    pend_h [NP];
  bit    go = 1'b0;

  int    grant_q[$];
  txn_t  bus_q[$];
  resp_t resp_q[$];
  int    model_ptr = 0;

  int    checks   = 0;
  int    failures = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  task automatic add_req(input int p, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int waits, input logic [31:0] rdata);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.be = be;
    t.waits = waits; t.rdata = rdata;
    pend[p][pend_n[p]] = t;
    pend_n[p]++;
  endtask

  // Model: every loaded request is visible at once; each grant goes to the first
  // pending port at or after the pointer, which then moves past the winner.
  task automatic launch();
    int    h[NP];
    int    g, p;
    txn_t  t;
    resp_t r;
    for (int k = 0; k < NP; k++) h[k] = 0;
    g = 0;
    while (g >= 0) begin
      g = -1;
      for (int k = 0; k < NP; k++) begin
        p = (model_ptr + k) % NP;
        if (g < 0 && h[p] < pend_n[p]) g = p;
      end
      if (g >= 0) begin
        t = pend[g][h[g]];
        grant_q.push_back(g);
        bus_q.push_back(t);
        r.port  = g;
        r.err   = (t.waits >= WL);
        r.wr    = t.wr;
        r.rdata = t.rdata;
        r.len   = r.err ? WL : t.waits + 1;
        resp_q.push_back(r);
        h[g]++;
        model_ptr = (g + 1) % NP;
      end
    end
    go = 1'b1;
  endtask

  task automatic clear_stimulus();
    go = 1'b0;
    for (int k = 0; k < NP; k++) begin
      pend_h[k] = 0;
      pend_n[k] = 0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      done = (grant_q.size() == 0 && bus_q.size() == 0 && resp_q.size() == 0 && !busy);
      for (int k = 0; k < NP; k++) if (pend_h[k] != pend_n[k]) done = 1'b0;
    end
    if (!done) begin
      flagFail("drain_timeout");
      grant_q.delete();
      bus_q.delete();
      resp_q.delete();
    end
    clear_stimulus();
  endtask

  task automatic applyStimulus();
    launch();
    drain();
  endtask

  // Requesters present their queue head and advance after an acceptance pulse.
  logic [NP-1:0] acc_seen = '0;
  always @(negedge clk) acc_seen = req_ready;

  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      if (go && req_valid[p] && acc_seen[p]) pend_h[p]++;
      if (go && pend_h[p] < pend_n[p]) begin
        req_valid[p]              = 1'b1;
        req_write[p]              = pend[p][pend_h[p]].wr;
        req_addr[p*32 +: 32]      = pend[p][pend_h[p]].addr;
        req_wdata[p*32 +: 32]     = pend[p][pend_h[p]].wdata;
        req_byteenable[p*4 +: 4]  = pend[p][pend_h[p]].be;
      end else begin
        req_valid[p] = 1'b0;
      end
    end
  end

  // Grant monitor.
  always @(negedge clk) begin
    int g;
    if (reset && req_ready != '0) begin
      if (grant_q.size() == 0) flagFail("grant_unexpected");
      else begin
        g = grant_q.pop_front();
        checkOutput("grant", req_ready, 128'(4'b0001 << g));
      end
    end
  end

  // Avalon slave: checks every active beat against the expected transaction and
  // inserts that transaction's wait states.
  txn_t cur;
  int   cur_w = 0;
  bit   prev_active = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_active = 1'b0;
      waitrequest = 1'b1;
    end else if (read || write) begin
      if (!prev_active) begin
        if (bus_q.size() == 0) flagFail("bus_unexpected");
        else cur = bus_q.pop_front();
        cur_w = 0;
      end
      prev_active = 1'b1;
      checkOutput("bus_dir", {read, write}, {~cur.wr, cur.wr});
      checkOutput("bus_addr", address, cur.addr);
      checkOutput("bus_wdata", writedata, cur.wdata);
      checkOutput("bus_be", byteenable, cur.be);
      if (cur_w < cur.waits) begin
        waitrequest = 1'b1;
        cur_w++;
      end else begin
        waitrequest = 1'b0;
      end
      readdata = cur.rdata;
    end else begin
      prev_active = 1'b0;
      waitrequest = 1'b1;
    end
  end

  // Response monitor; resp_rdata must hold the last successful read value.
  int          active_cnt = 0;
  logic [31:0] exp_hold   = '0;
  resp_t       rm;
  always @(negedge clk) begin
    if (!reset) begin
      active_cnt = 0;
      exp_hold   = '0;
    end else begin
      if (read || write) active_cnt++;
      if (resp_valid != '0) begin
        if (resp_q.size() == 0) flagFail("resp_unexpected");
        else begin
          rm = resp_q.pop_front();
          if (!rm.wr && !rm.err) exp_hold = rm.rdata;
          checkOutput("resp_port", resp_valid, 128'(4'b0001 << rm.port));
          checkOutput("resp_err", resp_err, rm.err);
          checkOutput("resp_rdata", resp_rdata, exp_hold);
          checkOutput("bus_cycles", active_cnt, rm.len);
          checkOutput("resp_rw_low", {read, write}, 2'b00);
        end
        active_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, grants;
    clear_stimulus();

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_outputs", {req_ready, resp_valid, resp_err, resp_rdata, address,
                writedata, byteenable, read, write, busy}, '0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_rw", {read, write}, 2'b00);

    $display("[TB] single zero-wait read");
    add_req(1, 1'b0, 32'h0000_1004, $urandom, 4'hF, 0, 32'hDEAD_BEEF);
    applyStimulus();

    $display("[TB] write with three wait states");
    add_req(0, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 3, $urandom);
    applyStimulus();

    $display("[TB] timeout then normal read");
    add_req(3, 1'b0, 32'h0000_3000, $urandom, 4'hF, 100, $urandom);
    applyStimulus();
    add_req(2, 1'b0, 32'h0000_3004, $urandom, 4'hF, 0, 32'hCAFE_0001);
    applyStimulus();

    $display("[TB] reset during a wait state");
    add_req(1, 1'b0, 32'h0000_4000, $urandom, 4'hF, 100, $urandom);
    launch();
    n = 0;
    for (int cyc = 0; cyc < 50 && n < 2; cyc++) begin
      @(negedge clk);
      if (read) n++;
    end
    if (n < 2) flagFail("midbus_start");
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("midbus_reset_outputs", {req_ready, resp_valid, resp_err, resp_rdata, address,
                writedata, byteenable, read, write, busy}, '0);
    grant_q.delete();
    bus_q.delete();
    resp_q.delete();
    clear_stimulus();
    model_ptr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] all ports requesting continuously");
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 2; k++)
        add_req(p, 1'b0, 32'h0000_5000 + 32'(16*p + 4*k), $urandom, 4'hF, 0, $urandom);
    applyStimulus();

    $display("[TB] randomized rounds");
    for (int round = 0; round < 25; round++) begin
      for (int p = 0; p < NP; p++) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++)
          add_req(p, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                  4'($urandom_range(1, 15)),
                  ($urandom_range(0, 9) > 7) ? 6 : $urandom_range(0, 3), $urandom);
      end
      applyStimulus();
    end

    $display("[TB] fixed priority with all ports requesting");
    @(posedge clk);
    #1 fp_req_valid = '1;
    grants = 0;
    for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
      @(negedge clk);
      if (fp_req_ready != '0) begin
        checkOutput("fp_grant", fp_req_ready, 4'b0001);
        grants++;
      end
    end
    if (grants < 5) flagFail("fp_grant_count");
    fp_req_valid = '0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised Avalon-MM master front-end that lets `NUM_PORTS` internal requesters share one memory bus. Candidate requesters are the instruction-fetch path, data load/store path and future DMA or debug ports. It holds one bus transaction in flight at a time, arbitrates round-robin or fixed-priority, honours `waitrequest`, and returns registered read data to the requester. An optional wait-limit aborts hung transactions with an error flag. It sits between CPU-side memory units and the top-level Avalon pins.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of requesters; minimum 2, maximum 8.
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `WAIT_LIMIT`, 0: maximum consecutive `waitrequest`-high cycles before abort; 0 disables the timeout.

Ports (per-port vectors are flattened, with port i in slice i):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_PORTS  request pending per port; held until accepted.
- `req_write`  in  NUM_PORTS  1 = write, 0 = read.
- `req_addr`  in  32*NUM_PORTS  byte address.
- `req_wdata`  in  32*NUM_PORTS  write data.
- `req_byteenable`  in  4*NUM_PORTS  byte lanes.
- `req_ready`  out  NUM_PORTS  one-cycle acceptance pulse, one-hot or zero.
- `resp_valid`  out  NUM_PORTS  one-cycle completion pulse, one-hot or zero.
- `resp_err`  out  1  qualifies `resp_valid`; 1 = aborted by timeout.
- `resp_rdata`  out  32  read data, valid with `resp_valid` for reads and undefined for writes.
- `address`, `writedata`, `byteenable`, `read`, `write`  out  32/32/4/1/1  Avalon master outputs.
- `waitrequest`  in  1; `readdata`  in  32  Avalon inputs.
- `busy`  out  1  high whenever state is BUS.

## Operation
- States are IDLE and BUS.
- **IDLE:**
  - If no `req_valid` bit is set, the block stays in IDLE.
  - Otherwise it picks a winner g and pulses `req_ready[g]` combinationally in the same cycle.
  - At the clock edge it latches addr, wdata, byteenable and write for port g, stores grant index g, clears the wait counter and goes to BUS.
- **Round-robin:**
  - Search starts at pointer `ptr` and wraps modulo NUM_PORTS; the first set `req_valid` wins.
  - On acceptance, `ptr` ← (g+1) mod NUM_PORTS.
  - `ptr` resets to 0.
- **Fixed priority:** the lowest set index wins; `ptr` is unused.
- **BUS:**
  - `address`/`writedata`/`byteenable` are driven from the latched registers.
  - `read` = ~latched write and `write` = latched write; both are held constant for the whole BUS residency.
- **Completion:** BUS with `waitrequest`=0 at a rising edge. At that edge:
  - `resp_valid[g]` ← 1 and `resp_err` ← 0.
  - `resp_rdata` ← `readdata` for reads; it holds its previous value for writes.
  - State ← IDLE.
- **Timeout:**
  - Applies only when WAIT_LIMIT>0. The wait counter increments on each BUS edge with `waitrequest`=1.
  - When it would reach WAIT_LIMIT, the next state is IDLE, with `resp_valid[g]` ← 1 and `resp_err` ← 1.
  - `read`/`write` drop on the following cycle.
- `req_*` inputs of non-granted ports are ignored. A requester may change its inputs freely after its `req_ready` pulse.
- **Reset, asserted at any time including mid-transaction:**
  - Immediately, all outputs go to 0 and the state goes to IDLE. `ptr`, the wait counter and the latched request are cleared.
  - No `resp_valid` is issued for the killed transaction.

## Timing
- Acceptance at edge E0 (IDLE cycle with `req_ready`): `read`/`write` are high from E0 until the completion edge.
- Zero-wait transaction: BUS lasts 1 cycle, and `resp_valid` is high in the cycle after the completion edge.
- Minimum issue interval is 2 cycles per transaction. A new acceptance may occur in the same cycle that `resp_valid` is high, because that cycle is an IDLE cycle.
- Wait states: each `waitrequest`=1 cycle extends BUS by one cycle.
- Simultaneous requests from all ports are served one per transaction in arbitration order. Under round-robin no port waits more than NUM_PORTS transactions.
- `req_ready` and `resp_valid` are never high for more than one cycle per transaction.

## Test plan
- **Reset values:** reset low with `waitrequest`=1 and reads in flight → all outputs are 0 immediately. After release with no requests, the block stays IDLE with `read`=`write`=0.
- **Single read, zero wait:**
  - Stimulus: port 1 reads 0x0000_1004 with `readdata`=0xDEAD_BEEF and `waitrequest`=0.
  - Response: `req_ready`=2'b10, then `read`=1 with `address`=0x1004 for 1 cycle, then `resp_valid`=2'b10 with `resp_rdata`=0xDEADBEEF and `resp_err`=0.
- **Wait states on a write:**
  - Stimulus: port 0 writes 0x1234_5678 with byteenable 4'b0011 while `waitrequest` is held 3 cycles.
  - Response: `write`=1 for exactly 4 cycles with stable outputs, then one `resp_valid[0]` pulse.
- **Round-robin fairness:**
  - Stimulus: NUM_PORTS=4, all ports requesting continuously, zero wait.
  - Response: grant order 0,1,2,3,0. Repeating with ARB_MODE=1 gives port 0 every grant.
- **Timeout:**
  - Stimulus: WAIT_LIMIT=5, `waitrequest` stuck at 1.
  - Response: `resp_valid` with `resp_err`=1 after 5 BUS cycles. `read` then drops, and the next request is accepted normally.
- **Reset mid-BUS:** reset pulsed during a wait state → no `resp_valid`; the first grant after release goes to port 0 (`ptr`=0).
